filt_addr_gen: RTL and testbench
================================

// Module: filt_addr_gen
// PURPOSE
//  Parametrised address generator for the filter accelerators; successor to the fixed 32-bit
//  offset+counter calculator. Emits FILESIZE addresses (in 128-bit words) starting at OFFSET,
//  with runtime stride and a valid/ready handshake to the memory request port.
//  Supports pause, abort, zero-length jobs and explicit address wrap; sits between job control and the read/write port.
// PARAMETERS
//  ADDR_W      32  width of offset/stride/addr
//  CNT_W       32  width of filesize/count
//  BYTE_SHIFT  4   log2(bytes per word); step = stride << BYTE_SHIFT (16 B for 128-bit words)
// PORTS
//  clk         in   1       clock, all logic on rising edge
//  rst         in   1       synchronous, active-high reset
//  start       in   1       launch job; sampled only in IDLE or DONE
//  offset      in   ADDR_W  byte base address, latched on accepted start
//  filesize    in   CNT_W   number of words to address, latched on accepted start
//  stride      in   ADDR_W  word stride (1 = contiguous), latched on accepted start
//  pause       in   1       hold generation; no handshake while high
//  abort       in   1       cancel job, return to IDLE
//  addr_ready  in   1       consumer accepts addr this cycle
//  addr_valid  out  1       addr is valid
//  addr        out  ADDR_W  current byte address
//  count       out  CNT_W   number of addresses accepted so far in this job
//  busy        out  1       high in RUN
//  done        out  1       high in DONE (level), job finished normally
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE, addr=0, count=0, addr_valid=0, busy=0, done=0;
//    latched offset/filesize/stride cleared. Reset overrides every other input, including mid-job.
//  - FSM states IDLE, RUN, DONE. Priority per cycle: rst > abort > start > handshake.
//  - IDLE/DONE + start: latch inputs; addr<=offset, count<=0, done<=0;
//    next state RUN if filesize!=0, else DONE (done=1 the next cycle, no address emitted).
//  - start in RUN is ignored (no relatch, no restart).
//  - addr_valid = (state==RUN) & ~pause (combinational from state reg and pause).
//    Exception to the handshake stability rule: pause may drop valid while addr is unaccepted.
//    addr is held stable until accepted.
//  - Handshake fires when addr_valid & addr_ready. On fire:
//    count<=count+1; addr<=addr+(stride<<BYTE_SHIFT) mod 2^ADDR_W (silent wrap, no flag).
//    If count==filesize-1 at fire: next state DONE, busy<=0, done<=1.
//  - The first address is available the cycle after start (latency 1).
//    Peak throughput is 1 address/cycle with addr_ready held high.
//  - In DONE: addr and count hold their final values (count==filesize) until the next start or abort.
//  - abort in RUN or DONE: next state IDLE, done=0, busy=0, addr_valid=0 next cycle; count/addr hold.
//    An abort in the same cycle as a fire: the fire still counts as accepted by the consumer,
//    but state goes to IDLE, not DONE.
//  - abort in IDLE: no effect. start and abort together: abort wins.
//  - stride=0 is legal: the same address is repeated filesize times.
//  - Arithmetic is unsigned; stride<<BYTE_SHIFT is truncated to ADDR_W. filesize=2^CNT_W-1 must complete.
// TESTING
//  1 Basic: offset=0x1000, filesize=4, stride=1, ready=1
//    -> addr 0x1000,0x1010,0x1020,0x1030 on 4 consecutive cycles; done=1 the cycle after the 4th; count=4.
//  2 Backpressure/pause: same job, ready toggles 1,0,0,1 and pause pulses mid-run
//    -> addr stable while unaccepted; valid=0 during pause; exactly 4 fires, no skipped or duplicated address.
//  3 Wrap and stride: offset=0xFFFF_FFE0, stride=1, filesize=3 -> 0xFFFF_FFE0,0xFFFF_FFF0,0x0000_0000.
//    Then stride=3 from offset 0 -> 0x00,0x30,0x60.
//  4 Zero length: filesize=0 start -> addr_valid never asserts; done=1 one cycle after start.
//  5 Abort and reset: abort after 2 fires of an 8-word job -> IDLE, done=0, count=2.
//    rst mid-run -> all outputs 0 next cycle. A new start then runs normally.
//  6 Ignored start and restart: start pulsed in RUN -> no effect on the sequence.
//    start in DONE with new offset -> done=0, new sequence begins next cycle.

Source files
------------

// File: rtl/filt_addr_gen.sv
// Strided word-address generator: first address 1 cycle after start, up to 1 address/cycle.
// Backpressure: addr is held until addr_valid & addr_ready; pause drops addr_valid without advancing.
module filt_addr_gen #(
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 32,
    parameter int BYTE_SHIFT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] offset,
    input  logic [CNT_W-1:0]  filesize,
    input  logic [ADDR_W-1:0] stride,
    input  logic              pause,
    input  logic              abort,
    input  logic              addr_ready,
    output logic              addr_valid,
    output logic [ADDR_W-1:0] addr,
    output logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [CNT_W-1:0]  filesize_q, filesize_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [ADDR_W-1:0] step;
    logic              fire;

    // Byte step per accepted address; overflow past ADDR_W is deliberately dropped.
    assign step       = stride_q << BYTE_SHIFT;
    assign addr_valid = (state_q == ST_RUN) && !pause;
    assign fire       = addr_valid && addr_ready;
    assign addr       = addr_q;
    assign count      = count_q;
    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        offset_d   = offset_q;
        filesize_d = filesize_q;
        stride_d   = stride_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    offset_d   = offset;
                    filesize_d = filesize;
                    stride_d   = stride;
                    addr_d     = offset;
                    count_d    = '0;
                    state_d    = (filesize != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                // A fire coincident with abort is still consumed, but the job ends in IDLE.
                if (fire) begin
                    count_d = count_q + CNT_W'(1);
                    addr_d  = addr_q + step;
                    if (abort) begin
                        state_d = ST_IDLE;
                    end else if (count_q + CNT_W'(1) == filesize_q) begin
                        state_d = ST_DONE;
                    end
                end else if (abort) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            offset_q   <= '0;
            filesize_q <= '0;
            stride_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            offset_q   <= offset_d;
            filesize_q <= filesize_d;
            stride_q   <= stride_d;
        end
    end

endmodule

// File: tb/tb_filt_addr_gen.sv
// Directed bench for filt_addr_gen with hand-computed expected addresses and flags.
module tb_filt_addr_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] offset;
    logic [31:0] filesize;
    logic [31:0] stride;
    logic        pause;
    logic        abort;
    logic        addr_ready;
    logic        addr_valid;
    logic [31:0] addr;
    logic [31:0] count;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    filt_addr_gen #(.ADDR_W(32), .CNT_W(32), .BYTE_SHIFT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .offset     (offset),
        .filesize   (filesize),
        .stride     (stride),
        .pause      (pause),
        .abort      (abort),
        .addr_ready (addr_ready),
        .addr_valid (addr_valid),
        .addr       (addr),
        .count      (count),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [31:0] off, input logic [31:0] fs, input logic [31:0] str);
        offset   = off;
        filesize = fs;
        stride   = str;
        start    = 1'b1;
        step();
        start    = 1'b0;
        #1;
    endtask

    logic [31:0] exp_addr [8];
    logic        bp_ready [8];
    logic        bp_pause [8];
    logic        bp_valid [8];
    logic [31:0] bp_count [8];

    initial begin
        rst = 1'b1; start = 1'b0; offset = '0; filesize = '0; stride = '0;
        pause = 1'b0; abort = 1'b0; addr_ready = 1'b0;
        step();
        step();
        chk("rst_valid", addr_valid, 0);
        chk("rst_addr",  addr, 0);
        chk("rst_count", count, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        rst = 1'b0;

        // Basic contiguous job
        addr_ready = 1'b1;
        launch(32'h1000, 4, 1);
        exp_addr[0] = 32'h1000; exp_addr[1] = 32'h1010; exp_addr[2] = 32'h1020; exp_addr[3] = 32'h1030;
        chk("basic_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("basic_valid%0d", i), addr_valid, 1);
            chk($sformatf("basic_addr%0d", i), addr, exp_addr[i]);
            step();
        end
        chk("basic_done",  done, 1);
        chk("basic_busy0", busy, 0);
        chk("basic_count", count, 4);
        chk("basic_valid_end", addr_valid, 0);

        // Backpressure and pause on the same job, restarted from DONE
        bp_ready = '{1, 0, 0, 1, 1, 1, 0, 1};
        bp_pause = '{0, 0, 0, 0, 1, 0, 1, 0};
        bp_valid = '{1, 1, 1, 1, 0, 1, 0, 1};
        exp_addr = '{32'h1000, 32'h1010, 32'h1010, 32'h1010, 32'h1020, 32'h1020, 32'h1030, 32'h1030};
        bp_count = '{0, 1, 1, 1, 2, 2, 3, 3};
        launch(32'h1000, 4, 1);
        chk("bp_done_cleared", done, 0);
        for (int i = 0; i < 8; i++) begin
            addr_ready = bp_ready[i];
            pause      = bp_pause[i];
            #1;
            chk($sformatf("bp_valid%0d", i), addr_valid, bp_valid[i]);
            chk($sformatf("bp_addr%0d", i), addr, exp_addr[i]);
            chk($sformatf("bp_count%0d", i), count, bp_count[i]);
            step();
        end
        pause = 1'b0; addr_ready = 1'b1;
        chk("bp_done",  done, 1);
        chk("bp_count", count, 4);

        // Address wrap through 2^32
        launch(32'hFFFF_FFE0, 3, 1);
        exp_addr[0] = 32'hFFFF_FFE0; exp_addr[1] = 32'hFFFF_FFF0; exp_addr[2] = 32'h0000_0000;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wrap_addr%0d", i), addr, exp_addr[i]);
            step();
        end
        chk("wrap_done", done, 1);

        // Stride 3
        launch(32'h0, 3, 3);
        exp_addr[0] = 32'h00; exp_addr[1] = 32'h30; exp_addr[2] = 32'h60;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stride_addr%0d", i), addr, exp_addr[i]);
            step();
        end
        chk("stride_done", done, 1);
        chk("stride_count", count, 3);

        // Zero-length job
        launch(32'h8000, 0, 1);
        chk("zero_valid", addr_valid, 0);
        chk("zero_done",  done, 1);
        chk("zero_busy",  busy, 0);
        chk("zero_count", count, 0);
        step();
        chk("zero_valid2", addr_valid, 0);

        // Abort after two fires
        launch(32'h2000, 8, 1);
        step();
        step();
        chk("abort_pre_count", count, 2);
        addr_ready = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        #1;
        chk("abort_busy",  busy, 0);
        chk("abort_done",  done, 0);
        chk("abort_valid", addr_valid, 0);
        chk("abort_count", count, 2);
        chk("abort_addr",  addr, 32'h2020);

        // Abort in IDLE together with start: abort wins, nothing launches
        abort = 1'b1; start = 1'b1; offset = 32'h7000; filesize = 5;
        step();
        abort = 1'b0; start = 1'b0;
        #1;
        chk("idle_abort_busy",  busy, 0);
        chk("idle_abort_count", count, 2);
        chk("idle_abort_addr",  addr, 32'h2020);

        // Abort coincident with a fire
        addr_ready = 1'b1;
        launch(32'h6000, 8, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        #1;
        chk("abort_fire_busy",  busy, 0);
        chk("abort_fire_done",  done, 0);
        chk("abort_fire_count", count, 1);
        chk("abort_fire_addr",  addr, 32'h6010);

        // Reset mid-run, then a normal job
        launch(32'h2000, 8, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mrst_valid", addr_valid, 0);
        chk("mrst_addr",  addr, 0);
        chk("mrst_count", count, 0);
        chk("mrst_busy",  busy, 0);
        chk("mrst_done",  done, 0);
        launch(32'h3000, 2, 1);
        chk("post_rst_addr0", addr, 32'h3000);
        step();
        chk("post_rst_addr1", addr, 32'h3010);
        step();
        chk("post_rst_done", done, 1);
        chk("post_rst_count", count, 2);

        // start while running is ignored
        launch(32'h4000, 4, 1);
        exp_addr[0] = 32'h4000; exp_addr[1] = 32'h4010; exp_addr[2] = 32'h4020; exp_addr[3] = 32'h4030;
        for (int i = 0; i < 4; i++) begin
            start  = (i < 3);
            offset = 32'h9000; filesize = 9; stride = 5;
            #1;
            chk($sformatf("ign_addr%0d", i), addr, exp_addr[i]);
            chk($sformatf("ign_count%0d", i), count, i);
            step();
        end
        start = 1'b0;
        #1;
        chk("ign_done",  done, 1);
        chk("ign_count", count, 4);

        // Restart from DONE with a new offset
        launch(32'h5000, 2, 1);
        chk("restart_done",  done, 0);
        chk("restart_valid", addr_valid, 1);
        chk("restart_addr",  addr, 32'h5000);
        chk("restart_count", count, 0);
        step();
        chk("restart_addr1", addr, 32'h5010);
        step();
        chk("restart_fin", done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
